// File: rtl/cascade_game_pkg.sv
// Shared types and helpers for the cascaded-subsystem game blocks.
package cascade_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ROLL, S_ADJUST, S_EVAL, S_RESULT, S_DONE, S_OVER
  } state_t;

  // Default 5-subsystem, 3-level tables; level 0 lives in the LSBs.
  localparam logic [14:0] DEF_EXP_TABLE = {5'b00111, 5'b00111, 5'b01111};
  localparam logic [14:0] DEF_ESS_TABLE = {5'b00011, 5'b00111, 5'b01111};

  // Number of set bits in a cascade-width vector (up to 16 subsystems).
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Pull one level's n_sub-bit row out of a flattened table.
  function automatic logic [15:0] tbl_slice(input logic [127:0] tbl,
                                            input int unsigned n_sub,
                                            input logic [2:0] lvl);
    logic [127:0] sh;
    sh = tbl >> (int'(lvl) * n_sub);
    return sh[15:0] & 16'((17'h1 << n_sub) - 17'h1);
  endfunction

endpackage

// File: rtl/cascade_game_ctrl_if.sv
// Player/UI-side signal bundle of the game controller.
// Optional score output exists only with CASCADE_GAME_SCORE_EN defined.
interface cascade_game_ctrl_if #(parameter int N_SUB = 5) ();
  logic             start;
  logic             commit;
  logic [N_SUB-1:0] sw_off;
  logic [N_SUB-1:0] r_out;
  logic [N_SUB-1:0] o_out;
  logic [2:0]       level;
  logic [1:0]       tries;
  logic             level_passed;
  logic             level_failed;
  logic             game_won;
  logic             game_over;
  logic             busy;
`ifdef CASCADE_GAME_SCORE_EN
  logic [7:0]       score;
`endif

  modport master (
    output start, commit, sw_off,
    input  r_out, o_out, level, tries, level_passed, level_failed,
           game_won, game_over, busy
`ifdef CASCADE_GAME_SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  start, commit, sw_off,
    output r_out, o_out, level, tries, level_passed, level_failed,
           game_won, game_over, busy
`ifdef CASCADE_GAME_SCORE_EN
    , output score
`endif
  );
endinterface

// File: rtl/cascade_game_ctrl_lfsr_xnor_gen.sv
// Free-running XNOR-feedback LFSR; shifts left, feedback enters at bit 0.
module lfsr_xnor_gen #(
  parameter int                LFSR_W    = 5,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100,
  parameter logic [LFSR_W-1:0] SEED      = 5'b00001
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);
  logic fb;

  assign fb = ~^(lfsr & LFSR_TAPS);

  // Step once per clock; all-ones is the lock-up state, so SEED avoids it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {lfsr[LFSR_W-2:0], fb};
  end
endmodule

// File: rtl/cascade_game_ctrl.sv
// Multi-level round controller for the cascaded-subsystem game.
// Optional: CASCADE_GAME_SCORE_EN adds a saturating 8-bit score.
module cascade_game_ctrl
  import cascade_game_pkg::*;
#(
  parameter int                         N_SUB     = 5,
  parameter int                         LFSR_W    = 5,
  parameter logic [LFSR_W-1:0]          LFSR_TAPS = 5'b10100,
  parameter logic [LFSR_W-1:0]          SEED      = 5'b00001,
  parameter int                         N_LEVELS  = 3,
  parameter logic [N_LEVELS*N_SUB-1:0]  EXP_TABLE = DEF_EXP_TABLE,
  parameter logic [N_LEVELS*N_SUB-1:0]  ESS_TABLE = DEF_ESS_TABLE,
  parameter int                         MAX_TRIES = 3,
  parameter int                         WIN_CYC   = 16
) (
  input logic                clk,
  input logic                rst,
  cascade_game_ctrl_if.slave bus
);
  localparam int WCW = $clog2(WIN_CYC + 1);

  state_t           state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [N_SUB-1:0] r_cap, r_q, off_q, o_q;
  logic [N_SUB-1:0] e_sl, s_sl, o_c, ok;
  logic [WCW-1:0]   win_cnt;
  logic             win_last, pass_c, pass_q;
  logic [2:0]       level_q;
  logic [1:0]       tries_q;
  logic             passed_q, failed_q, won_q, over_q;

  lfsr_xnor_gen #(.LFSR_W(LFSR_W), .LFSR_TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign e_sl     = N_SUB'(tbl_slice(128'(EXP_TABLE), N_SUB, level_q));
  assign s_sl     = N_SUB'(tbl_slice(128'(ESS_TABLE), N_SUB, level_q));
  assign win_last = (win_cnt == WCW'(WIN_CYC - 1));

  // Enable cascade: a stage only drives if the stage before it is acceptable.
  for (genvar i = 0; i < N_SUB; i++) begin : g_casc
    if (i == 0) begin : g_head
      assign o_c[i] = r_q[i] & ~off_q[i];
    end else begin : g_link
      assign o_c[i] = ok[i-1] ? (r_q[i] & ~off_q[i]) : 1'b0;
    end
    assign ok[i] = (o_c[i] == e_sl[i]) | ~s_sl[i];
  end

  assign pass_c = &(~s_sl | ~(o_c ^ e_sl));

  // Round state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Round sequencing: start/commit only matter in the states that own them.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_ROLL;
      S_ROLL:   state_nxt = S_ADJUST;
      S_ADJUST: if (bus.commit || win_last) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = S_RESULT;
      S_RESULT: begin
        if (pass_q) state_nxt = (level_q == 3'(N_LEVELS - 1)) ? S_DONE : S_IDLE;
        else        state_nxt = (tries_q == 2'(MAX_TRIES - 1)) ? S_OVER : S_IDLE;
      end
      S_DONE, S_OVER: if (bus.start) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Round datapath: capture random bits, switches, cascade result, progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap <= '0; r_q <= '0; off_q <= '0; o_q <= '0; win_cnt <= '0;
      pass_q <= 1'b0; level_q <= '0; tries_q <= '0;
      passed_q <= 1'b0; failed_q <= 1'b0; won_q <= 1'b0; over_q <= 1'b0;
    end else begin
      passed_q <= 1'b0;
      failed_q <= 1'b0;
      case (state)
        S_IDLE:   if (bus.start) r_cap <= lfsr[N_SUB-1:0];
        S_ROLL:   begin r_q <= r_cap; win_cnt <= '0; end
        S_ADJUST: begin
          if (bus.commit || win_last) off_q <= bus.sw_off;
          else                        win_cnt <= win_cnt + WCW'(1);
        end
        S_EVAL:   begin o_q <= o_c; pass_q <= pass_c; end
        S_RESULT: begin
          if (pass_q) begin
            passed_q <= 1'b1;
            if (level_q == 3'(N_LEVELS - 1)) won_q <= 1'b1;
            else begin level_q <= level_q + 3'd1; tries_q <= '0; end
          end else begin
            failed_q <= 1'b1;
            if (tries_q == 2'(MAX_TRIES - 1)) over_q <= 1'b1;
            else tries_q <= tries_q + 2'd1;
          end
        end
        S_DONE, S_OVER: if (bus.start) begin
          level_q <= '0; tries_q <= '0; won_q <= 1'b0; over_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CASCADE_GAME_SCORE_EN
  logic [7:0] score_q;
  logic [8:0] score_sum;

  // Switching off non-essential subsystems costs points; the gain is >= 1.
  assign score_sum = {1'b0, score_q} + 9'(N_SUB + 1)
                   - 9'(popcount(16'(off_q & ~s_sl)));

  // Score accrues on each pass, saturates, and clears on game restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) score_q <= '0;
    else if (state == S_RESULT && pass_q)
      score_q <= score_sum[8] ? 8'hff : score_sum[7:0];
    else if ((state == S_DONE || state == S_OVER) && bus.start)
      score_q <= '0;
  end

  assign bus.score = score_q;
`endif

  assign bus.r_out        = r_q;
  assign bus.o_out        = o_q;
  assign bus.level        = level_q;
  assign bus.tries        = tries_q;
  assign bus.level_passed = passed_q;
  assign bus.level_failed = failed_q;
  assign bus.game_won     = won_q;
  assign bus.game_over    = over_q;
  assign bus.busy         = !(state == S_IDLE || state == S_DONE || state == S_OVER);
endmodule
